// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and types for the load/store unit.
// Width codes, memory access modes and controller states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] MEM_BYTE = 3'b000;
  localparam logic [2:0] MEM_WORD = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  // Stores only exist for B/H/W; loads add BU/HU.
  function automatic logic f3_legal(input logic we,
                                    input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    unique case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: sign/zero extension of an assembled load word.
// Purely combinational; selects width from funct3.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  // Extend the low byte/half according to the width code.
  always_comb begin
    data_o = word_i;
    unique case (funct3_i)
      F3_B:    data_o = {{24{word_i[7]}}, word_i[7:0]};
      F3_H:    data_o = {{16{word_i[15]}}, word_i[15:0]};
      F3_BU:   data_o = {24'b0, word_i[7:0]};
      F3_HU:   data_o = {16'b0, word_i[15:0]};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator toward word-organised data memory.
// Splits misaligned/narrow accesses into little-endian byte accesses.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [2:0]            mem_funct,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            last_q, last_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [2:0]            mem_funct_q, mem_funct_d;

  logic [DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] ext_data;
  logic                  req_word;
  logic [1:0]            req_last;
  logic [1:0]            nxt;

  // Merge this cycle's read data into the load assembly word.
  always_comb begin
    cur_word = word_q;
    if (mem_funct_q == MEM_WORD)
      cur_word = mem_rd_data;
    else
      cur_word[{cnt_q, 3'b000} +: 8] = mem_rd_data[7:0];
  end

  lsu_load_ext u_ext (
    .word_i   (cur_word),
    .funct3_i (f3_q),
    .data_o   (ext_data)
  );

  // Access plan for an incoming request: word mode and last index.
  always_comb begin
    req_word = 1'b0;
    req_last = 2'd0;
    unique case (req_funct3)
      F3_W: begin
        req_word = (req_addr[1:0] == 2'b00);
        req_last = req_word ? 2'd0 : 2'd3;
      end
      F3_H, F3_HU: req_last = 2'd1;
      default:     req_last = 2'd0;
    endcase
  end

  // Next-state and registered-output logic of the controller.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    f3_d          = f3_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    word_d        = word_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = resp_valid_q;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    wr_en_d       = wr_en_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_funct_d   = mem_funct_q;
    nxt           = cnt_q + 2'd1;
    unique case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        wr_en_d     = 1'b0;
        if (req_valid) begin
          we_d        = req_we;
          f3_d        = req_funct3;
          wdata_d     = req_wdata;
          cnt_d       = 2'd0;
          last_d      = req_last;
          word_d      = '0;
          req_ready_d = 1'b0;
          if (f3_legal(req_we, req_funct3)) begin
            state_d     = S_ACCESS;
            wr_en_d     = req_we;
            mem_addr_d  = req_addr;
            mem_funct_d = req_word ? MEM_WORD : MEM_BYTE;
            mem_wr_data_d = req_word ? req_wdata :
              {{(DATA_WIDTH-8){1'b0}}, req_wdata[7:0]};
          end else begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end
        end
      end
      S_ACCESS: begin
        word_d = cur_word;
        if (cnt_q == last_q) begin
          state_d      = S_RESP;
          wr_en_d      = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = we_q ? '0 : ext_data;
        end else begin
          cnt_d         = nxt;
          mem_addr_d    = mem_addr_q + 1'b1;
          mem_wr_data_d = {{(DATA_WIDTH-8){1'b0}},
                           wdata_q[{nxt, 3'b000} +: 8]};
        end
      end
      S_RESP: begin
        wr_en_d = 1'b0;
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      we_q          <= 1'b0;
      f3_q          <= F3_W;
      wdata_q       <= '0;
      cnt_q         <= 2'd0;
      last_q        <= 2'd0;
      word_q        <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_funct_q   <= MEM_WORD;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      f3_q          <= f3_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      word_q        <= word_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      wr_en_q       <= wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_funct_q   <= mem_funct_d;
    end
  end

  // A reset arriving mid-store suppresses the write of that same cycle.
  assign mem_wr_en   = wr_en_q & ~reset;
  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_funct   = mem_funct_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized and directed checks of lsu_ctrl against a
// byte-level memory model and a per-request expectation model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [2:0]  mem_funct;
  logic [31:0] mem_rd_data;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mem [256];
  logic [7:0] gold [256];

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_funct   (mem_funct),
    .mem_rd_data (mem_rd_data)
  );

  // Data memory: byte array, word mode at the given address.
  logic [7:0] ma;
  always_comb begin
    ma = mem_addr[7:0];
    if (mem_funct == 3'b010)
      mem_rd_data = {mem[ma + 8'd3], mem[ma + 8'd2],
                     mem[ma + 8'd1], mem[ma]};
    else
      mem_rd_data = {24'b0, mem[ma]};
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      if (mem_funct == 3'b010) begin
        mem[ma]        <= mem_wr_data[7:0];
        mem[ma + 8'd1] <= mem_wr_data[15:8];
        mem[ma + 8'd2] <= mem_wr_data[23:16];
        mem[ma + 8'd3] <= mem_wr_data[31:24];
      end else begin
        mem[ma] <= mem_wr_data[7:0];
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Cycle-wide invariants: no write outside ACCESS, clean byte data.
  always @(negedge clk) begin
    if (!reset) begin
      check("wr_outside_access",
            {31'b0, mem_wr_en & (resp_valid | req_ready)}, 32'd0);
      check("byte_wdata_upper",
            (mem_wr_en && mem_funct == 3'b000) ?
              {8'b0, mem_wr_data[31:8]} : 32'd0, 32'd0);
    end
  end

  task automatic check_reset_vals();
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wr_data", mem_wr_data, 32'd0);
    check("rst_mem_funct", {29'b0, mem_funct}, 32'd2);
  endtask

  // One request end to end; expectations come from the byte model.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd);
    logic        legal;
    int          size, n;
    logic        wmode;
    logic [31:0] raw, exp_rd, exp_wd;
    logic [7:0]  idx;
    legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
            && !(we && f3[2]);
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    wmode = (size == 4) && (a[1:0] == 2'b00);
    n     = wmode ? 1 : size;
    raw   = '0;
    for (int k = 0; k < size; k++) begin
      idx = 8'(a + 32'(k));
      raw[8*k +: 8] = gold[idx];
    end
    exp_rd = raw;
    if (f3 == 3'b000 && raw[7])  exp_rd = raw | 32'hFFFFFF00;
    if (f3 == 3'b001 && raw[15]) exp_rd = raw | 32'hFFFF0000;
    if (we || !legal) exp_rd = '0;
    if (we && legal)
      for (int k = 0; k < size; k++) begin
        idx = 8'(a + 32'(k));
        gold[idx] = wd[8*k +: 8];
      end

    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = $urandom_range(0, 1);
    req_funct3 = 3'($urandom); req_addr = $urandom;
    req_wdata = $urandom;
    if (legal)
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        exp_wd = wmode ? wd : {24'b0, wd[8*k +: 8]};
        check("acc_addr", mem_addr, a + 32'(k));
        check("acc_we", {31'b0, mem_wr_en}, {31'b0, we});
        check("acc_funct", {29'b0, mem_funct},
              wmode ? 32'd2 : 32'd0);
        if (we) check("acc_wdata", mem_wr_data, exp_wd);
        check("acc_busy", {30'b0, resp_valid, req_ready}, 32'd0);
        @(posedge clk); #1;
      end
    @(negedge clk);
    check("resp_valid", {31'b0, resp_valid}, 32'd1);
    check("resp_err", {31'b0, resp_err}, {31'b0, !legal});
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_ready_lo", {31'b0, req_ready}, 32'd0);
    rd = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_valid", {31'b0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, exp_rd);
      check("hold_err", {31'b0, resp_err}, {31'b0, !legal});
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("release_valid", {31'b0, resp_valid}, 32'd0);
    check("release_ready", {31'b0, req_ready}, 32'd1);
  endtask

  logic [31:0] rd;
  logic [2:0]  rf3;
  logic        rwe;

  initial begin
    for (int i = 0; i < 256; i++) gold[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals();

    // Clear the whole memory through the unit.
    for (int i = 0; i < 256; i += 4)
      do_req(1'b1, 3'b010, 32'(i), 32'h0, 0, rd);

    do_req(1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 0, rd);
    do_req(1'b0, 3'b010, 32'h08, 32'h0, 0, rd);
    check("lit_lw", rd, 32'hDEADBEEF);

    do_req(1'b1, 3'b000, 32'h05, 32'h12345680, 0, rd);
    do_req(1'b0, 3'b000, 32'h05, 32'h0, 1, rd);
    check("lit_lb", rd, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 32'h05, 32'h0, 0, rd);
    check("lit_lbu", rd, 32'h00000080);

    do_req(1'b1, 3'b001, 32'h03, 32'h0000F234, 0, rd);
    check("lit_sh_b0", {24'b0, mem[8'h03]}, 32'h34);
    check("lit_sh_b1", {24'b0, mem[8'h04]}, 32'hF2);
    do_req(1'b0, 3'b001, 32'h03, 32'h0, 0, rd);
    check("lit_lh", rd, 32'hFFFFF234);
    do_req(1'b0, 3'b101, 32'h03, 32'h0, 0, rd);
    check("lit_lhu", rd, 32'h0000F234);

    do_req(1'b1, 3'b010, 32'h10, 32'h44332211, 0, rd);
    do_req(1'b1, 3'b010, 32'h14, 32'h88776655, 0, rd);
    do_req(1'b0, 3'b010, 32'h12, 32'h0, 0, rd);
    check("lit_lw_mis", rd, 32'h66554433);

    do_req(1'b1, 3'b011, 32'h40, 32'hFFFFFFFF, 3, rd);
    check("lit_err_rdata", rd, 32'h0);

    do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, rd);

    // Misaligned store interrupted by reset after its first byte.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h21; req_wdata = 32'hAABBCCDD;
    @(negedge clk);
    check("rst_req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_acc0_addr", mem_addr, 32'h21);
    check("rst_acc0_data", mem_wr_data, 32'hDD);
    check("rst_acc0_we", {31'b0, mem_wr_en}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_no_write", {31'b0, mem_wr_en}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    gold[8'h21] = 8'hDD;
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, rd);
    check("lit_after_rst", rd, 32'h0000DD00);

    // Random traffic, including illegal codes and holds.
    for (int i = 0; i < 300; i++) begin
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      do_req(rwe, rf3, $urandom, $urandom,
             $urandom_range(0, 2), rd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit that acts as the initiator toward the word-organised data memory.
- Accepts one load/store request from the core per handshake.
- Issues one word access or a sequence of byte accesses, assembles and sign/zero-extends load data, and returns one response.
- Sits between the core's memory stage and the data memory, using the memory's byte mode (funct 000) and word mode (funct 010).

Parameters:
- DATA_WIDTH, 32, data width; only 32 is supported.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset; one clock, all state updates on posedge clk
- req_valid  in  1  core request valid
- req_ready  out  1  unit idle and able to accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts the response
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores
- resp_err  out  1  illegal funct3
- mem_wr_en  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory byte address
- mem_wr_data  out  DATA_WIDTH  memory write data
- mem_funct  out  3  000 = byte access, 010 = word access
- mem_rd_data  in  DATA_WIDTH  combinational memory read data; byte mode returns the byte zero-extended in [7:0]

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_wr_en 0, mem_addr 0, mem_wr_data 0, mem_funct 010, access counter 0.
- Reset mid-operation: the in-flight request is dropped; no further mem_wr_en; bytes already written stay written.
- IDLE: req_ready = 1. On req_valid in cycle T, latch we, funct3, addr and wdata.
  - Legal request: go to ACCESS.
  - Illegal funct3 (011, 110, 111, or a store with funct3[2] = 1): go to RESP with resp_err = 1 and no memory access.
- Access count N:
  - W with addr[1:0] = 00: N = 1, mem_funct 010.
  - W misaligned: N = 4.
  - H/HU: N = 2.
  - B/BU: N = 1.
  - All N > 1 accesses, and all byte accesses, use mem_funct 000.
- ACCESS lasts exactly N cycles (T+1 … T+N).
  - Access k (k = 0..N-1) drives mem_addr = addr + k, wrapping modulo 2^ADDR_WIDTH.
  - Byte order is little-endian: access k carries bits [8k+7:8k].
- Stores:
  - mem_wr_en = 1 in every ACCESS cycle.
  - Byte mode: mem_wr_data = {24'b0, byte k}. The upper bits MUST be zero because the memory ORs the whole word into the target lane.
  - Word mode: mem_wr_data = wdata.
- Loads:
  - mem_wr_en = 0.
  - Capture mem_rd_data at the end of each ACCESS cycle: mem_rd_data[7:0] into byte lane k, or the full word in word mode.
- After the last access go to RESP (cycle T+N+1) with resp_valid = 1.
  - resp_rdata: B/H sign-extend from bit 7/15; BU/HU zero-extend; W unchanged.
- RESP: hold resp_valid and resp_rdata/resp_err stable until resp_ready = 1.
  - resp_ready = 1: resp_valid drops and state returns to IDLE the next cycle.
  - req_ready = 0 in ACCESS and RESP; there is no request pipelining.
  - Minimum occupancy per request: N + 2 cycles with resp_ready held high.
- mem_wr_en = 0 in IDLE and RESP under all conditions.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - mem_funct constants (MEM_BYTE = 000, MEM_WORD = 010).
  - FSM state encoding.
- One sub-module, lsu_load_ext: combinational assembled-word + funct3 → extended resp_rdata.

Test Plan:
- SW addr 0x08, data 0xDEADBEEF, then LW 0x08 → each request gives one access with mem_funct 010; resp_rdata = 0xDEADBEEF, resp_err 0, resp_valid at T+2.
- SB addr 0x05, data 0x12345680 → mem_wr_data = 0x00000080. Then LB 0x05 → 0xFFFFFF80; LBU 0x05 → 0x00000080.
- SH addr 0x03, data 0x0000F234 → two byte writes, addr 0x03 = 0x34 then addr 0x04 = 0xF2. Then LH 0x03 → 0xFFFFF234; LHU 0x03 → 0x0000F234.
- SW 0x10 = 0x44332211, SW 0x14 = 0x88776655, then LW 0x12 → four byte reads at 0x12..0x15; resp_rdata = 0x66554433, resp_valid at T+5.
- Store with req_funct3 = 011 → resp_err 1 and resp_valid at T+1; mem_wr_en never asserted. Then hold resp_ready = 0 for 3 cycles → resp_valid held, req_ready 0.
- Misaligned SW at 0x21, data 0xAABBCCDD, with reset asserted in the second ACCESS cycle:
  - only byte 0xDD is written at 0x21;
  - after reset, all outputs are at reset values and req_ready = 1;
  - LW 0x20 → 0x0000DD00.
